song_reader: RTL

- Note sequencer: the initiator side of the note-player handshake.
- Walks a song stored in an external synchronous song ROM and issues one note per handshake (note_to_load, duration, load_new_note pulse).
- Waits for note_done before fetching the next entry; signals end of song.
- Sits between the top-level MCU/play control and the note player.

---
 rtl/song_reader_pkg.sv | 42 ++++
 rtl/song_reader_if.sv | 41 ++++
 rtl/dffre.sv | 22 ++
 rtl/song_reader_addr_counter.sv | 40 ++++
 rtl/song_reader.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/song_reader_pkg.sv
// song_reader_pkg: shared definitions for the song reader.
//   - state_t   : FSM state encoding (3 bits, IDLE..HALT)
//   - ROM entry field positions and the end-of-song marker duration
//   - helper functions that split a ROM entry into its fields
package song_reader_pkg;

  localparam int STATE_WIDTH = 3;
  localparam int ROM_WIDTH   = 12;
  localparam int FIELD_WIDTH = 6;

  localparam int NOTE_MSB = 11;
  localparam int NOTE_LSB = 6;
  localparam int DUR_MSB  = 5;
  localparam int DUR_LSB  = 0;

  localparam logic [FIELD_WIDTH-1:0] END_MARKER_DUR = 6'd0;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_LOAD   = 3'd3,
    ST_ARM    = 3'd4,
    ST_WAIT   = 3'd5,
    ST_END    = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  function automatic logic [FIELD_WIDTH-1:0] entry_note(input logic [ROM_WIDTH-1:0] entry);
    return entry[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [FIELD_WIDTH-1:0] entry_dur(input logic [ROM_WIDTH-1:0] entry);
    return entry[DUR_MSB:DUR_LSB];
  endfunction

  // A zero duration marks the end of a song; such an entry is never played.
  function automatic logic entry_is_end(input logic [ROM_WIDTH-1:0] entry);
    return (entry[DUR_MSB:DUR_LSB] == END_MARKER_DUR);
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// song_reader_if: song ROM bus plus note-player handshake.
//   rom_addr      reader -> ROM     {song, note index}
//   rom_data      ROM -> reader     entry, valid one cycle after rom_addr
//   note_to_load  reader -> player  note of the current entry
//   duration      reader -> player  duration of the current entry
//   load_new_note reader -> player  one-cycle load strobe
//   note_done     player -> reader  high while the player's count is zero
// Modports: master = song reader side, slave = ROM / note player side.
interface song_reader_if
  import song_reader_pkg::*;
#(
  parameter int NOTE_ADDR_WIDTH = 5,
  parameter int SONG_WIDTH      = 2
);

  logic [SONG_WIDTH+NOTE_ADDR_WIDTH-1:0] rom_addr;
  logic [ROM_WIDTH-1:0]                  rom_data;
  logic [FIELD_WIDTH-1:0]                note_to_load;
  logic [FIELD_WIDTH-1:0]                duration;
  logic                                  load_new_note;
  logic                                  note_done;

  modport master (
    output rom_addr,
    output note_to_load,
    output duration,
    output load_new_note,
    input  rom_data,
    input  note_done
  );

  modport slave (
    input  rom_addr,
    input  note_to_load,
    input  duration,
    input  load_new_note,
    output rom_data,
    output note_done
  );

endinterface

// File: rtl/dffre.sv
// dffre: D flip-flop with synchronous active-high reset (to zero) and enable.
//   clk, reset, en, d[WIDTH] -> q[WIDTH]
module dffre #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over enable; otherwise load d when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= {WIDTH{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/song_reader_addr_counter.sv
// song_addr_counter: note index within the current song.
//   clear has priority over inc; inc is ignored at the last index so the
//   index never wraps -- the FSM uses last to leave for END instead.
//   Ports: clk, reset, clear, inc -> idx[WIDTH], last
module song_addr_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] idx,
  output logic             last
);

  logic [WIDTH-1:0] idx_next;
  logic             idx_en;

  // Next index: zero on clear, otherwise one step forward.
  always_comb begin
    idx_next = {WIDTH{1'b0}};
    if (clear) begin
      idx_next = {WIDTH{1'b0}};
    end else begin
      idx_next = idx + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign last   = &idx;
  assign idx_en = clear | (inc & ~last);

  dffre #(.WIDTH(WIDTH)) u_idx (
    .clk   (clk),
    .reset (reset),
    .en    (idx_en),
    .d     (idx_next),
    .q     (idx)
  );

endmodule

// File: rtl/song_reader.sv
// song_reader: note sequencer, initiator side of the note-player handshake.
// Walks one song of a synchronous song ROM and hands each entry to the note
// player, waiting for note_done between entries.
//   clk, reset    : clock, synchronous active-high reset
//   play          : level, low freezes the sequencer
//   song          : selected song; a change restarts from entry 0
//   song_done     : one-cycle pulse at end of song
//   bus (master)  : rom_addr/rom_data and note_to_load/duration/
//                   load_new_note/note_done
// Build option SONG_LOOP_EN: after END the song restarts at entry 0 instead
// of parking in HALT.
module song_reader
  import song_reader_pkg::*;
#(
  parameter int NOTE_ADDR_WIDTH = 5,
  parameter int SONG_WIDTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic [SONG_WIDTH-1:0] song,
  output logic                  song_done,
  song_reader_if.master         bus
);

  state_t                     state;
  state_t                     next_state;
  logic [STATE_WIDTH-1:0]     state_bits;
  logic [SONG_WIDTH-1:0]      song_q;
  logic [NOTE_ADDR_WIDTH-1:0] note_idx;
  logic                       last_idx;
  logic                       song_change;
  logic                       is_marker;
  logic                       active;

  logic                       load_pulse;
  logic                       done_pulse;
  logic                       song_q_en;
  logic                       entry_en;
  logic                       idx_clear;
  logic                       idx_inc;

  // A song change outside IDLE aborts the current song.
  assign song_change = (state != ST_IDLE) && (song != song_q);
  assign is_marker   = entry_is_end(bus.rom_data);
  assign active      = play && !song_change;

  // State register.
  dffre #(.WIDTH(STATE_WIDTH)) u_state (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (next_state),
    .q     (state_bits)
  );
  assign state = state_t'(state_bits);

  // Next-state logic: song change first, then play freezes, then sequencing.
  always_comb begin
    next_state = state;
    if (song_change) begin
      next_state = ST_IDLE;
    end else if (!play) begin
      next_state = state;
    end else begin
      case (state)
        ST_IDLE:   next_state = ST_FETCH;
        ST_FETCH:  next_state = ST_DECODE;
        ST_DECODE: begin
          if (is_marker) begin
            next_state = ST_END;
          end else begin
            next_state = ST_LOAD;
          end
        end
        ST_LOAD:   next_state = ST_ARM;
        // The player still shows the previous note's done level here.
        ST_ARM:    next_state = ST_WAIT;
        ST_WAIT: begin
          if (!bus.note_done) begin
            next_state = ST_WAIT;
          end else if (last_idx) begin
            next_state = ST_END;
          end else begin
            next_state = ST_FETCH;
          end
        end
`ifdef SONG_LOOP_EN
        ST_END:    next_state = ST_FETCH;
`else
        ST_END:    next_state = ST_HALT;
`endif
        ST_HALT:   next_state = ST_HALT;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // Output and datapath-enable decode; pulses are gated with play and
  // suppressed during reset and on a song change.
  always_comb begin
    load_pulse = 1'b0;
    done_pulse = 1'b0;
    song_q_en  = 1'b0;
    entry_en   = 1'b0;
    idx_clear  = 1'b0;
    idx_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        song_q_en = play;
        idx_clear = 1'b1;
      end
      ST_DECODE: begin
        entry_en = active && !is_marker;
      end
      ST_LOAD: begin
        load_pulse = active && !reset;
      end
      ST_WAIT: begin
        idx_inc = active && bus.note_done;
      end
      ST_END: begin
        done_pulse = active && !reset;
`ifdef SONG_LOOP_EN
        idx_clear  = active;
`else
        idx_clear  = 1'b0;
`endif
      end
      default: begin
        load_pulse = 1'b0;
      end
    endcase
    if (song_change) begin
      idx_clear = 1'b1;
    end else begin
      idx_clear = idx_clear;
    end
  end

  // Song latched on leaving IDLE.
  dffre #(.WIDTH(SONG_WIDTH)) u_song_q (
    .clk   (clk),
    .reset (reset),
    .en    (song_q_en),
    .d     (song),
    .q     (song_q)
  );

  // Note and duration captured from the ROM in DECODE.
  dffre #(.WIDTH(FIELD_WIDTH)) u_note (
    .clk   (clk),
    .reset (reset),
    .en    (entry_en),
    .d     (entry_note(bus.rom_data)),
    .q     (bus.note_to_load)
  );

  dffre #(.WIDTH(FIELD_WIDTH)) u_dur (
    .clk   (clk),
    .reset (reset),
    .en    (entry_en),
    .d     (entry_dur(bus.rom_data)),
    .q     (bus.duration)
  );

  song_addr_counter #(.WIDTH(NOTE_ADDR_WIDTH)) u_addr (
    .clk   (clk),
    .reset (reset),
    .clear (idx_clear),
    .inc   (idx_inc),
    .idx   (note_idx),
    .last  (last_idx)
  );

  assign bus.rom_addr      = {song_q, note_idx};
  assign bus.load_new_note = load_pulse;
  assign song_done         = done_pulse;

endmodule
